// File: rtl/aer_pkg.sv
// Shared AER definitions: handshake FSM state type, handshake level constants
// and a helper that sizes the gate window counter. Also intended for use by
// the AER receiver.
// No ports (package).
package aer_pkg;

    // 4-phase handshake sender states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } aer_state_t;

    // Handshake line levels.
    localparam logic AER_REQ_ASSERT = 1'b1;
    localparam logic AER_REQ_IDLE   = 1'b0;
    localparam logic AER_ACK_ASSERT = 1'b1;

    // Counter width able to hold 0..duration. At least one bit, so that a
    // zero-length window still gets a well-formed (always-zero) counter.
    function automatic int cnt_width(input int duration);
        if (duration > 0) begin
            return $clog2(duration + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/aer_priority_arbiter.sv
// Picks one pending channel and returns it as a one-hot grant and a binary
// address.
// Build option AER_GATE_RR_EN: when defined, round-robin search starting at
// the channel after the last granted one (pointer kept here, advanced on
// take). When undefined, fixed priority with the lowest index winning and no
// state at all.
// Ports:
//   clk, reset (AER_GATE_RR_EN only) clock / async active-low reset of pointer
//   take       (AER_GATE_RR_EN only) current grant is being accepted
//   pending    candidate channels
//   grant      one-hot winner (all zero when nothing pending)
//   addr       binary index of the winner
module aer_priority_arbiter
    import aer_pkg::*;
#(
    parameter int NUM_CH = 5,
    localparam int ADDR_W = $clog2(NUM_CH)
)
(
`ifdef AER_GATE_RR_EN
    input  logic              clk,
    input  logic              reset,
    input  logic              take,
`endif
    input  logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] grant,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic              lo_any_s;
    logic [ADDR_W-1:0] lo_idx_s;
    logic              sel_any_s;
    logic [ADDR_W-1:0] sel_idx_s;

    // Lowest pending index overall (the downward scan leaves the lowest hit).
    always_comb begin
        lo_any_s = 1'b0;
        lo_idx_s = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) begin
                lo_any_s = 1'b1;
                lo_idx_s = ADDR_W'(c);
            end else begin
                lo_any_s = lo_any_s;
                lo_idx_s = lo_idx_s;
            end
        end
    end

`ifdef AER_GATE_RR_EN
    logic [ADDR_W-1:0] ptr_r;
    logic              hi_any_s;
    logic [ADDR_W-1:0] hi_idx_s;

    // Lowest pending index at or above the pointer; the wrapped search falls
    // back to the lowest index overall when nothing lies above the pointer.
    always_comb begin
        hi_any_s = 1'b0;
        hi_idx_s = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c] && (ADDR_W'(c) >= ptr_r)) begin
                hi_any_s = 1'b1;
                hi_idx_s = ADDR_W'(c);
            end else begin
                hi_any_s = hi_any_s;
                hi_idx_s = hi_idx_s;
            end
        end
    end

    // Winner selection for round-robin.
    always_comb begin
        sel_any_s = lo_any_s;
        if (hi_any_s) begin
            sel_idx_s = hi_idx_s;
        end else begin
            sel_idx_s = lo_idx_s;
        end
    end

    // Pointer moves to the channel after the accepted grant, wrapping at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (take) begin
            if (sel_idx_s == ADDR_W'(NUM_CH - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= sel_idx_s + ADDR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Winner selection for fixed priority.
    always_comb begin
        sel_any_s = lo_any_s;
        sel_idx_s = lo_idx_s;
    end
`endif

    // Encode the winner.
    always_comb begin
        addr = sel_idx_s;
        if (sel_any_s) begin
            grant = ONE_HOT0 << sel_idx_s;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/aer_spike_gate.sv
// AER front end: per-channel spike edge capture, arbitration onto a 4-phase
// req/ack address bus, and a retriggerable gate window.
// Build option AER_GATE_RR_EN selects round-robin arbitration (default build:
// fixed priority, lowest channel wins).
// Ports:
//   clk       clock, all state on posedge
//   reset     asynchronous, active-low
//   spikes    raw spike levels, one per channel (sampled, never used as clock)
//   gate_en   high while the gate window counter is non-zero
//   aer_req   AER request (registered)
//   aer_addr  granted channel, stable while aer_req is high (registered)
//   aer_ack   AER acknowledge from the receiver
//   pending   captured events not yet acknowledged
//   overflow  sticky: an event arrived on a channel that was still pending
module aer_spike_gate
    import aer_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int DURATION = 15,
    localparam int ADDR_W  = $clog2(NUM_CH)
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] spikes,
    output logic              gate_en,
    output logic              aer_req,
    output logic [ADDR_W-1:0] aer_addr,
    input  logic              aer_ack,
    output logic [NUM_CH-1:0] pending,
    output logic              overflow
);

    localparam int CNT_W = cnt_width(DURATION);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0] prev_r;
    logic [NUM_CH-1:0] ev_s;
    logic [NUM_CH-1:0] clr_s;
    logic [NUM_CH-1:0] pend_nxt_s;
    logic              ovf_set_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    aer_state_t        state_r;
    aer_state_t        state_nxt_s;
    logic              req_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [NUM_CH-1:0] grant_s;
    logic [ADDR_W-1:0] grant_addr_s;

`ifdef AER_GATE_RR_EN
    logic take_s;

    // A grant is accepted exactly when the FSM leaves IDLE.
    always_comb begin
        take_s = (state_r == IDLE) && (|grant_s);
    end

    aer_priority_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .take    (take_s),
        .pending (pending),
        .grant   (grant_s),
        .addr    (grant_addr_s)
    );
`else
    aer_priority_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .pending (pending),
        .grant   (grant_s),
        .addr    (grant_addr_s)
    );
`endif

    // Rising-edge detect: a level held for many cycles counts once.
    always_comb begin
        ev_s = spikes & ~prev_r;
    end

    // Acknowledge of the current grant clears its pending bit. A new event on
    // that same edge re-arms the bit instead of counting as a loss.
    always_comb begin
        if ((state_r == REQ) && (aer_ack == AER_ACK_ASSERT)) begin
            clr_s = ONE_HOT0 << aer_addr;
        end else begin
            clr_s = '0;
        end
        pend_nxt_s = (pending & ~clr_s) | ev_s;
        ovf_set_s  = |(ev_s & pending & ~clr_s);
    end

    // Gate window: any event reloads the full duration, otherwise count down to 0.
    always_comb begin
        if (|ev_s) begin
            cnt_nxt_s = CNT_W'(DURATION);
        end else if (cnt_r != '0) begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Capture, pending, overflow and gate window state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r   <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            cnt_r    <= '0;
            gate_en  <= 1'b0;
        end else begin
            prev_r   <= spikes;
            pending  <= pend_nxt_s;
            overflow <= overflow | ovf_set_s;
            cnt_r    <= cnt_nxt_s;
            gate_en  <= (cnt_nxt_s != '0);
        end
    end

    // Handshake FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake FSM next state. Acknowledge is ignored while IDLE.
    always_comb begin
        case (state_r)
            IDLE: begin
                if (|grant_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (aer_ack == AER_ACK_ASSERT) begin
                    state_nxt_s = ACK_LOW;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            ACK_LOW: begin
                if (aer_ack != AER_ACK_ASSERT) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK_LOW;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake outputs: address latched only when a grant is taken from IDLE.
    always_comb begin
        if (state_nxt_s == REQ) begin
            req_nxt_s = AER_REQ_ASSERT;
        end else begin
            req_nxt_s = AER_REQ_IDLE;
        end
        if ((state_r == IDLE) && (|grant_s)) begin
            addr_nxt_s = grant_addr_s;
        end else begin
            addr_nxt_s = aer_addr;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aer_req  <= AER_REQ_IDLE;
            aer_addr <= '0;
        end else begin
            aer_req  <= req_nxt_s;
            aer_addr <= addr_nxt_s;
        end
    end

endmodule

// File: tb/tb_aer_spike_gate.sv
module tb_aer_spike_gate;

    localparam int NUM_CH   = 5;
    localparam int DURATION = 15;
    localparam int ADDR_W   = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] spikes;
    logic              gate_en;
    logic              aer_req;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_ack = 1'b0;
    logic [NUM_CH-1:0] pending;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    aer_spike_gate #(.NUM_CH(NUM_CH), .DURATION(DURATION)) dut (
        .clk      (clk),
        .reset    (reset),
        .spikes   (spikes),
        .gate_en  (gate_en),
        .aer_req  (aer_req),
        .aer_addr (aer_addr),
        .aer_ack  (aer_ack),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Abstract view: a set of pending channels, a sender that is idle, holding
    // a request, or waiting for ack to fall, and the edge index of the last
    // spike event (gate is open for DURATION edges after it).
    int                m_edge;
    int                m_last_ev;
    int                m_phase;      // 0 idle, 1 requesting, 2 waiting ack low
    int                m_cur;
    int                m_last_grant;
    logic [NUM_CH-1:0] m_prev;
    logic [NUM_CH-1:0] m_pend;
    logic              m_ovf;
    logic [NUM_CH-1:0] m_ev;
    logic [NUM_CH-1:0] m_clr;
    int                exp_q[$];

    function automatic int pick_ch(input logic [NUM_CH-1:0] p, input int last);
`ifdef AER_GATE_RR_EN
        for (int k = 1; k <= NUM_CH; k++) begin
            if (p[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
`else
        for (int k = 0; k < NUM_CH; k++) begin
            if (p[k]) return k + 0 * last;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edge = 0; m_last_ev = -1000; m_phase = 0; m_cur = 0;
            m_last_grant = NUM_CH - 1;
            m_prev = '0; m_pend = '0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            m_edge++;
            m_ev   = spikes & ~m_prev;
            m_prev = spikes;
            m_clr  = '0;
            if (m_phase == 0) begin
                if (m_pend != '0) begin
                    m_cur = pick_ch(m_pend, m_last_grant);
                    m_last_grant = m_cur;
                    exp_q.push_back(m_cur);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (aer_ack) begin
                    m_clr[m_cur] = 1'b1;
                    m_phase = 2;
                end
            end else begin
                if (!aer_ack) m_phase = 0;
            end
            if ((m_ev & m_pend & ~m_clr) != '0) m_ovf = 1'b1;
            m_pend = (m_pend & ~m_clr) | m_ev;
            if (m_ev != '0) m_last_ev = m_edge;
        end
    end

    // ---------------- monitor ----------------
    logic mon_prev_req = 1'b0;
    always @(negedge clk) begin
        int e;
        if (reset) begin
            check("gate_en", 32'(gate_en), 32'((m_edge - m_last_ev) < DURATION));
            check("pending", 32'(pending), 32'(m_pend));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("aer_req", 32'(aer_req), 32'(m_phase == 1));
            if (aer_req && !mon_prev_req) begin
                if (exp_q.size() == 0) begin
                    check("grant_expected", 32'(0), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("grant_addr", 32'(aer_addr), 32'(e));
                end
            end else if (aer_req) begin
                check("addr_hold", 32'(aer_addr), 32'(m_cur));
            end
            mon_prev_req = aer_req;
        end else begin
            mon_prev_req = 1'b0;
        end
    end

    // ---------------- AER receiver (ack responder) ----------------
    logic rand_ack = 1'b0;
    int   ack_dly  = 2;
    int   wait_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            aer_ack  = 1'b0;
            wait_cnt = 0;
        end else if (aer_ack) begin
            if (!aer_req) aer_ack = 1'b0;
        end else if (aer_req) begin
            wait_cnt++;
            if (wait_cnt >= ack_dly) begin
                aer_ack  = 1'b1;
                wait_cnt = 0;
                ack_dly  = rand_ack ? int'($urandom_range(1, 3)) : 2;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        reset  = 1'b0;
        spikes = '0;
        repeat (3) @(negedge clk);
        check("rst_gate_en", 32'(gate_en), 32'(0));
        check("rst_aer_req", 32'(aer_req), 32'(0));
        check("rst_aer_addr", 32'(aer_addr), 32'(0));
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Two channels in one cycle.
        spikes = 5'b01100; @(negedge clk); spikes = '0;
        repeat (40) @(negedge clk);
        check("t2_pending_end", 32'(pending), 32'(0));

        // Held level is a single event.
        spikes = 5'b00010; repeat (4) @(negedge clk); spikes = '0;
        repeat (30) @(negedge clk);

        // Second edge before ack -> overflow.
        spikes = 5'b00010; @(negedge clk); spikes = '0; @(negedge clk);
        spikes = 5'b00010; @(negedge clk); spikes = '0;
        repeat (30) @(negedge clk);
        check("t4_overflow", 32'(overflow), 32'(1));

        // Retrigger while counter is 1.
        spikes = 5'b00001; @(negedge clk); spikes = '0;
        repeat (14) @(negedge clk);
        spikes = 5'b00001; @(negedge clk); spikes = '0;
        repeat (40) @(negedge clk);

        // Channels 0 and 4 re-spiking continually.
        repeat (24) begin
            spikes = 5'b10001; @(negedge clk);
            spikes = '0;       @(negedge clk);
        end
        repeat (30) @(negedge clk);

        // Async reset in the middle of a handshake.
        spikes = 5'b00100; @(negedge clk); spikes = '0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (aer_req) found = 1'b1;
            else @(negedge clk);
        end
        check("t7_req_seen", 32'(found), 32'(1));
        #2 reset = 1'b0;
        #1;
        check("t7_aer_req", 32'(aer_req), 32'(0));
        check("t7_pending", 32'(pending), 32'(0));
        check("t7_overflow", 32'(overflow), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Randomized traffic with random ack latency.
        rand_ack = 1'b1;
        repeat (400) begin
            spikes = NUM_CH'($urandom & $urandom & $urandom);
            @(negedge clk);
        end
        spikes = '0;
        repeat (60) @(negedge clk);
        check("end_pending", 32'(pending), 32'(0));
        check("end_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
